// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction fetch PC unit.
//               FETCH_MISALIGN_TRAP_EN adds the TRAP state.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // 32-bit address / instruction word
    typedef logic [31:0] word_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
    localparam word_t DEFAULT_PC_STEP  = 32'd4;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        , TRAP = 2'd2
`endif
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_next_select.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_select
// Description : Combinational next-PC choice: redirect target, sequential
//               increment, or hold. Without FETCH_MISALIGN_TRAP_EN the
//               redirect target is forced word-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_select
    import fetch_pkg::*;
#(
    parameter word_t PC_STEP = DEFAULT_PC_STEP
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    output logic [31:0] next_pc
);

    logic [31:0] target;

    // Misaligned targets are kept as-is when the trap logic will catch them
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = redirect_target;
`else
    assign target = redirect_target & ~32'h0000_0003;
`endif

    // Redirect wins; increment wraps naturally at 32 bits
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = target;
        end else if (advance) begin
            next_pc = pc + PC_STEP;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction fetch PC sequencer. Issues one memory read per
//               instruction, holds the result until downstream accepts it,
//               and services branch/jump redirects with top priority.
//               FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC,
    parameter word_t PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    input  logic        redirect,
    input  logic [31:0] redirect_target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        trap
`endif
);

    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_HOLD  = 2'(HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_TRAP  = 2'(TRAP);
`endif

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        advance;
    logic        misaligned;

    assign imem_addr = pc;
    // The request is masked in the reset cycle so an aborted fetch is never seen
    assign imem_req  = (state == ST_FETCH) && !reset;
    assign advance   = (state == ST_FETCH) && imem_ack && !redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
    assign trap       = (state == ST_TRAP);
`else
    assign misaligned = 1'b0;
`endif

    pc_next_select #(
        .PC_STEP (PC_STEP)
    ) u_pc_next_select (
        .pc              (pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .advance         (advance),
        .next_pc         (next_pc)
    );

    // Fetch sequencer: redirect first, then memory ack, then downstream accept
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            state      <= ST_FETCH;
            inst_valid <= 1'b0;
            inst_out   <= 32'h0000_0000;
            pc_out     <= 32'h0000_0000;
        end else begin
            case (state)
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_TRAP: begin
                    // Parked until reset; redirects are ignored here
                    inst_valid <= 1'b0;
                end
`endif
                default: begin
                    if (redirect) begin
                        pc         <= next_pc;
                        inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        state      <= misaligned ? ST_TRAP : ST_FETCH;
`else
                        state      <= ST_FETCH;
`endif
                    end else if ((state == ST_FETCH) && imem_ack) begin
                        inst_out   <= imem_rdata;
                        pc_out     <= pc;
                        inst_valid <= 1'b1;
                        pc         <= next_pc;
                        state      <= ST_HOLD;
                    end else if ((state == ST_HOLD) && inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end
            endcase
        end
    end

    // misaligned only steers the trap transition; keep it referenced otherwise
    logic unused_ok;
    assign unused_ok = misaligned;

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameters SHALL be declared one per line: name, default, meaning.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 32'd4, sequential increment.

REQ-002 Ports SHALL be declared one per line: name, direction, width, meaning.
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- imem_req, output, 1, instruction-memory read request.
- imem_addr, output, 32, fetch address.
- imem_ack, input, 1, read complete; imem_rdata valid this cycle.
- imem_rdata, input, 32, fetched instruction word.
- inst_valid, output, 1, inst_out/pc_out hold a fetched instruction.
- inst_ready, input, 1, downstream accepts instruction.
- inst_out, output, 32, fetched instruction.
- pc_out, output, 32, address of inst_out.
- redirect, input, 1, branch/jump taken; replace PC.
- redirect_target, input, 32, new PC.
- trap, output, 1, misaligned-target flag; present only with the configuration macro.

REQ-003 Reset SHALL be reset, synchronous, active-high; the clock SHALL be clock.

Function
REQ-004 The block SHALL hold a 32-bit register pc; imem_addr SHALL equal pc at all times.
REQ-005 FSM states SHALL be FETCH, HOLD and TRAP; TRAP exists only with the configuration macro.
REQ-006 In FETCH, imem_req SHALL be 1, and it SHALL stay asserted with imem_addr stable until imem_ack.
REQ-007 In FETCH, on imem_ack without redirect, the block SHALL, at the next edge:
- inst_out <= imem_rdata;
- pc_out <= pc;
- inst_valid <= 1;
- pc <= pc + PC_STEP;
- state <= HOLD.
REQ-008 In HOLD:
- imem_req SHALL be 0.
- inst_valid SHALL be 1, with inst_out and pc_out stable.
- On inst_ready, inst_valid SHALL clear and the state SHALL return to FETCH at the next edge.
REQ-009 Latency SHALL be 1 cycle from imem_ack to inst_valid; peak throughput is one instruction per 2 cycles.
REQ-010 redirect SHALL have priority over every other event in every state. At the next edge:
- pc <= redirect_target;
- inst_valid <= 0;
- state <= FETCH.
REQ-011 An imem_ack coinciding with redirect SHALL be discarded: no inst_valid and no pc increment.
REQ-012 A redirect coinciding with inst_ready in HOLD SHALL treat the held instruction as consumed and take the redirect.
REQ-013 pc + PC_STEP SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-014 imem_ack received outside FETCH SHALL be ignored.

Reset
REQ-015 On reset the block SHALL set:
- pc = RESET_PC;
- state = FETCH;
- inst_valid = 0;
- inst_out = 0;
- pc_out = 0;
- trap = 0.
REQ-016 imem_req SHALL be 0 during the reset cycle and 1 in the first cycle after reset.
REQ-017 Reset mid-operation SHALL abort any outstanding request; an imem_ack arriving in the reset cycle SHALL be ignored.

Configuration
REQ-018 The macro FETCH_MISALIGN_TRAP_EN SHALL control misaligned-redirect handling.
REQ-019 When FETCH_MISALIGN_TRAP_EN is defined, a redirect with redirect_target[1:0] != 0 SHALL:
- load pc;
- enter TRAP.
REQ-020 In TRAP:
- trap = 1 and imem_req = 0;
- inst_valid = 0;
- redirect is ignored;
- only reset exits the state.
REQ-021 When FETCH_MISALIGN_TRAP_EN is undefined, the block SHALL have no trap port and no TRAP state, and it SHALL force redirect_target[1:0] to 2'b00 before loading pc.

Structure
REQ-022 Package fetch_pkg SHALL contain:
- the FSM state enum;
- the default RESET_PC and PC_STEP constants;
- the 32-bit address/word typedef.
REQ-023 Next-PC selection (increment vs redirect vs hold, including alignment forcing) SHALL be a combinational sub-module pc_next_select; the FSM and registers SHALL stay in fetch_pc_unit.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset with RESET_PC=32'h0000_0100, imem_ack after 1 cycle, inst_ready=1 -> pc_out sequence 0x100, 0x104, 0x108 with imem_rdata captured correctly.
- imem_ack delayed 3 cycles -> imem_req held high and imem_addr stable for all 3 cycles; inst_valid rises exactly 1 cycle after ack.
- inst_ready=0 for 4 cycles in HOLD -> inst_valid, inst_out and pc_out stable; imem_req=0 throughout.
- redirect to 32'h0000_2000 in the same cycle as imem_ack for 0x104 -> that instruction is never presented; the next pc_out is 0x2000.
- pc=32'hFFFF_FFFC fetch -> the next imem_addr is 32'h0000_0000.
- Redirect to 32'h0000_2002:
  - with FETCH_MISALIGN_TRAP_EN, trap=1 and imem_req=0 until reset;
  - without it, the next imem_addr is 32'h0000_2000.
